header_checksum_engine: RTL

Parametrised ones-complement header checksum engine for the outbound and inbound UDP/IPv4 paths. It accepts a variable-length header as a stream of DATA_W-bit beats, sums all 16-bit lanes end-around-carry, and returns the inverted 16-bit checksum on a valid/ready output. It supports IPv4 options (IHL 5..15), reports oversize headers, and can optionally check a received header. It sits between the header builder/parser and the packet assembler.

---
 rtl/header_checksum_engine_if.sv | 46 ++++
 rtl/header_checksum_engine.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/header_checksum_engine_if.sv
// Stream interface for header_checksum_engine: header beats in, checksum result out.
// The m_ok result signal exists only when CHECKSUM_VERIFY_EN is defined.
interface header_checksum_engine_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 4
);
  // Header beat stream (source -> engine)
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  // Result channel (engine -> consumer)
  logic              m_valid;
  logic              m_ready;
  logic [15:0]       m_checksum;
  logic [CNT_W-1:0]  m_words;
  logic              m_error;
`ifdef CHECKSUM_VERIFY_EN
  logic              m_ok;
`endif

`ifdef CHECKSUM_VERIFY_EN
  // Engine side: consumes beats, produces the result
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_checksum, m_words, m_error, m_ok
  );
  // Environment side: produces beats, consumes the result
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_checksum, m_words, m_error, m_ok
  );
`else
  // Engine side: consumes beats, produces the result
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_checksum, m_words, m_error
  );
  // Environment side: produces beats, consumes the result
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_checksum, m_words, m_error
  );
`endif
endinterface

// File: rtl/header_checksum_engine.sv
// header_checksum_engine: ones-complement checksum over a variable-length header.
// Every 16-bit lane of every beat is summed into a 32-bit accumulator; at the end
// of the header the sum is folded end-around-carry and inverted. Headers longer
// than MAX_WORDS beats are flagged and their excess beats are discarded.
// Optional feature macro: CHECKSUM_VERIFY_EN adds the m_ok verify result.
module header_checksum_engine #(
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  header_checksum_engine_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam int LANES = DATA_W / 16;

  typedef enum logic [1:0] {ACCUM, DROP, FOLD, RESULT} state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [31:0]       r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;

  logic [15:0]       r_checksum;
  logic [CNT_W-1:0]  r_words;
  logic              r_error;
`ifdef CHECKSUM_VERIFY_EN
  logic              r_ok;
`endif

  logic              w_s_ready;
  logic              w_beat;
  logic              w_acc_en;
  logic              w_set_err;
  logic              w_load;
  logic              w_clear;
  logic [15:0]       w_lane [LANES];
  logic [31:0]       w_beat_sum;
  logic [16:0]       w_f1;
  logic [15:0]       w_fold;

  // Split the beat into its 16-bit lanes
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign w_lane[gi] = bus.s_data[gi*16 +: 16];
  end

  // Plain binary sum of all lanes; carries stay in the upper accumulator half
  always_comb begin
    w_beat_sum = 32'd0;
    for (int i = 0; i < LANES; i++) begin
      w_beat_sum = w_beat_sum + {16'd0, w_lane[i]};
    end
  end

  // End-around-carry fold; the second add cannot carry out again
  always_comb begin
    w_f1   = {1'b0, r_acc[15:0]} + {1'b0, r_acc[31:16]};
    w_fold = w_f1[15:0] + {15'd0, w_f1[16]};
  end

  // Ready depends on state only and is held low while reset is asserted
  assign w_s_ready = !reset && ((r_state == ACCUM) || (r_state == DROP));
  assign w_beat    = bus.s_valid && w_s_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath strobes
  always_comb begin
    w_state_next = r_state;
    w_acc_en     = 1'b0;
    w_set_err    = 1'b0;
    w_load       = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      ACCUM: begin
        if (w_beat) begin
          w_acc_en = 1'b1;
          if (bus.s_last) begin
            w_state_next = FOLD;
          end else if (r_cnt == CNT_W'(MAX_WORDS - 1)) begin
            // This beat is the last one that fits; the rest of the header is dropped
            w_set_err    = 1'b1;
            w_state_next = DROP;
          end
        end
      end
      DROP: begin
        if (w_beat && bus.s_last) begin
          w_state_next = FOLD;
        end
      end
      FOLD: begin
        w_load       = 1'b1;
        w_state_next = RESULT;
      end
      RESULT: begin
        if (bus.m_ready) begin
          w_clear      = 1'b1;
          w_state_next = ACCUM;
        end
      end
      default: begin
        w_state_next = ACCUM;
      end
    endcase
  end

  // Accumulator, beat counter and oversize flag for the header in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= 32'd0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_clear) begin
      r_acc <= 32'd0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_acc_en) begin
        r_acc <= r_acc + w_beat_sum;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_set_err) begin
        r_err <= 1'b1;
      end
    end
  end

  // Result registers, captured in FOLD and held through RESULT
  always_ff @(posedge clk) begin
    if (reset) begin
      r_checksum <= 16'h0000;
      r_words    <= '0;
      r_error    <= 1'b0;
    end else if (w_load) begin
      r_checksum <= ~w_fold;
      r_words    <= r_cnt;
      r_error    <= r_err;
    end
  end

`ifdef CHECKSUM_VERIFY_EN
  // Verify result: a header carrying a correct checksum folds to all ones
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ok <= 1'b0;
    end else if (w_load) begin
      r_ok <= (w_fold == 16'hFFFF);
    end
  end

  assign bus.m_ok = r_ok;
`endif

  assign bus.s_ready    = w_s_ready;
  assign bus.m_valid    = (r_state == RESULT);
  assign bus.m_checksum = r_checksum;
  assign bus.m_words    = r_words;
  assign bus.m_error    = r_error;

endmodule
